// File: rtl/execute_stage.sv
// ============================================================================
//  Module   : execute_stage
//  Purpose  : EX stage of the 64-bit ARMv8-subset pipeline.
//             Forwarding muxes, ALU, branch-target adder, an iterative
//             multiplier that stalls the front end, and the EX/MEM register.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module execute_stage #(
    parameter int MUL_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_EX,
    input  logic        Branch_EX,
    input  logic        Uncondbranch_EX,
    input  logic        MemRead_EX,
    input  logic        MemWrite_EX,
    input  logic        Mem2Reg_EX,
    input  logic        ALUSrc_EX,
    input  logic [3:0]  ALUctrl_EX,
    input  logic [4:0]  RD_EX,
    input  logic [63:0] RegOutA_EX,
    input  logic [63:0] RegOutB_EX,
    input  logic [63:0] SignExtImm_EX,
    input  logic [63:0] pc_EX,
    input  logic [1:0]  ForwardA,
    input  logic [1:0]  ForwardB,
    input  logic [63:0] WriteData_WB,
    input  logic        flush_EX,
    output logic        stall_EX,
    output logic        RegWrite_MEM,
    output logic        Branch_MEM,
    output logic        Uncondbranch_MEM,
    output logic        MemRead_MEM,
    output logic        MemWrite_MEM,
    output logic        Mem2Reg_MEM,
    output logic [4:0]  RD_MEM,
    output logic [63:0] ALUout_MEM,
    output logic [63:0] RegOutB_MEM,
    output logic [63:0] PCtarget_MEM,
    output logic [63:0] pc_MEM,
    output logic        ALUzero_MEM
);

    localparam int K     = 64 / MUL_BITS;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_PASS = 4'b0111;
    localparam logic [3:0] C_MUL  = 4'b1000;
    localparam logic [3:0] C_LSL  = 4'b1001;
    localparam logic [3:0] C_LSR  = 4'b1010;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [63:0]      r_mul_a;
    logic [63:0]      r_mul_b;
    logic [63:0]      r_acc;

    logic [63:0] w_fwd_a;
    logic [63:0] w_fwd_b;
    logic [63:0] w_alu_b;
    logic [63:0] w_result;
    logic [63:0] w_pctarget;
    logic [63:0] w_partial;
    logic        w_mul_req;
    logic        w_stall;
    logic        w_bubble;

    always_comb begin
        w_fwd_a = RegOutA_EX;
        case (ForwardA)
            2'b10:   w_fwd_a = ALUout_MEM;
            2'b01:   w_fwd_a = WriteData_WB;
            default: w_fwd_a = RegOutA_EX;
        endcase
        w_fwd_b = RegOutB_EX;
        case (ForwardB)
            2'b10:   w_fwd_b = ALUout_MEM;
            2'b01:   w_fwd_b = WriteData_WB;
            default: w_fwd_b = RegOutB_EX;
        endcase
    end

    assign w_alu_b    = ALUSrc_EX ? SignExtImm_EX : w_fwd_b;
    assign w_pctarget = pc_EX + (SignExtImm_EX << 2);

    always_comb begin
        w_result = 64'd0;
        case (ALUctrl_EX)
            C_AND:   w_result = w_fwd_a & w_alu_b;
            C_OR:    w_result = w_fwd_a | w_alu_b;
            C_ADD:   w_result = w_fwd_a + w_alu_b;
            C_SUB:   w_result = w_fwd_a - w_alu_b;
            C_PASS:  w_result = w_alu_b;
            C_LSL:   w_result = w_fwd_a << w_alu_b[5:0];
            C_LSR:   w_result = w_fwd_a >> w_alu_b[5:0];
            C_MUL:   w_result = r_acc;
            default: w_result = 64'd0;
        endcase
    end

    // Stall is gated by flush (and reset) so a squashed MUL never holds the front end.
    assign w_mul_req = (ALUctrl_EX == C_MUL);
    assign w_stall   = !reset && !flush_EX &&
                       (((r_state == S_IDLE) && w_mul_req) || (r_state == S_BUSY));
    assign w_bubble  = w_stall || flush_EX;
    assign stall_EX  = w_stall;

    // A is pre-shifted each iteration, so each partial product lands in place.
    assign w_partial = r_mul_a * 64'(r_mul_b[MUL_BITS-1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mul_a <= 64'd0;
            r_mul_b <= 64'd0;
            r_acc   <= 64'd0;
        end else if (flush_EX) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mul_req) begin
                        r_state <= S_BUSY;
                        r_cnt   <= '0;
                        r_mul_a <= w_fwd_a;
                        r_mul_b <= w_alu_b;
                        r_acc   <= 64'd0;
                    end
                end
                S_BUSY: begin
                    r_acc   <= r_acc + w_partial;
                    r_mul_a <= r_mul_a << MUL_BITS;
                    r_mul_b <= r_mul_b >> MUL_BITS;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(K - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite_MEM     <= 1'b0;
            Branch_MEM       <= 1'b0;
            Uncondbranch_MEM <= 1'b0;
            MemRead_MEM      <= 1'b0;
            MemWrite_MEM     <= 1'b0;
            Mem2Reg_MEM      <= 1'b0;
            RD_MEM           <= 5'd0;
            ALUout_MEM       <= 64'd0;
            RegOutB_MEM      <= 64'd0;
            PCtarget_MEM     <= 64'd0;
            pc_MEM           <= 64'd0;
            ALUzero_MEM      <= 1'b0;
        end else if (w_bubble) begin
            RegWrite_MEM     <= 1'b0;
            Branch_MEM       <= 1'b0;
            Uncondbranch_MEM <= 1'b0;
            MemRead_MEM      <= 1'b0;
            MemWrite_MEM     <= 1'b0;
            Mem2Reg_MEM      <= 1'b0;
            RD_MEM           <= 5'd0;
            ALUout_MEM       <= 64'd0;
            RegOutB_MEM      <= 64'd0;
            PCtarget_MEM     <= 64'd0;
            pc_MEM           <= 64'd0;
            ALUzero_MEM      <= 1'b0;
        end else begin
            RegWrite_MEM     <= RegWrite_EX;
            Branch_MEM       <= Branch_EX;
            Uncondbranch_MEM <= Uncondbranch_EX;
            MemRead_MEM      <= MemRead_EX;
            MemWrite_MEM     <= MemWrite_EX;
            Mem2Reg_MEM      <= Mem2Reg_EX;
            RD_MEM           <= RD_EX;
            ALUout_MEM       <= w_result;
            RegOutB_MEM      <= w_fwd_b;
            PCtarget_MEM     <= w_pctarget;
            pc_MEM           <= pc_EX;
            ALUzero_MEM      <= (w_result == 64'd0);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// ============================================================================
//  Module   : tb_execute_stage
//  Purpose  : Scoreboard bench for execute_stage using directed vectors.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite_EX, Branch_EX, Uncondbranch_EX, MemRead_EX;
    logic        MemWrite_EX, Mem2Reg_EX, ALUSrc_EX;
    logic [3:0]  ALUctrl_EX;
    logic [4:0]  RD_EX;
    logic [63:0] RegOutA_EX, RegOutB_EX, SignExtImm_EX, pc_EX, WriteData_WB;
    logic [1:0]  ForwardA, ForwardB;
    logic        flush_EX;
    logic        stall_EX;
    logic        RegWrite_MEM, Branch_MEM, Uncondbranch_MEM, MemRead_MEM;
    logic        MemWrite_MEM, Mem2Reg_MEM, ALUzero_MEM;
    logic [4:0]  RD_MEM;
    logic [63:0] ALUout_MEM, RegOutB_MEM, PCtarget_MEM, pc_MEM;

    execute_stage #(.MUL_BITS(4)) dut (
        .clk(clk), .reset(reset),
        .RegWrite_EX(RegWrite_EX), .Branch_EX(Branch_EX),
        .Uncondbranch_EX(Uncondbranch_EX), .MemRead_EX(MemRead_EX),
        .MemWrite_EX(MemWrite_EX), .Mem2Reg_EX(Mem2Reg_EX), .ALUSrc_EX(ALUSrc_EX),
        .ALUctrl_EX(ALUctrl_EX), .RD_EX(RD_EX),
        .RegOutA_EX(RegOutA_EX), .RegOutB_EX(RegOutB_EX),
        .SignExtImm_EX(SignExtImm_EX), .pc_EX(pc_EX),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .WriteData_WB(WriteData_WB),
        .flush_EX(flush_EX), .stall_EX(stall_EX),
        .RegWrite_MEM(RegWrite_MEM), .Branch_MEM(Branch_MEM),
        .Uncondbranch_MEM(Uncondbranch_MEM), .MemRead_MEM(MemRead_MEM),
        .MemWrite_MEM(MemWrite_MEM), .Mem2Reg_MEM(Mem2Reg_MEM),
        .RD_MEM(RD_MEM), .ALUout_MEM(ALUout_MEM), .RegOutB_MEM(RegOutB_MEM),
        .PCtarget_MEM(PCtarget_MEM), .pc_MEM(pc_MEM), .ALUzero_MEM(ALUzero_MEM)
    );

    always #5 clk = ~clk;

    // ctl = {RegWrite, Branch, Uncondbranch, MemRead, MemWrite, Mem2Reg, ALUSrc}
    typedef struct packed {
        logic [6:0]  ctl;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [63:0] a, b, imm, pc;
        logic [1:0]  fa, fb;
        logic [63:0] wb;
        logic        fl;
    } in_t;

    // ctl6 = {RegWrite, Branch, Uncondbranch, MemRead, MemWrite, Mem2Reg}
    typedef struct packed {
        logic        stall;
        logic [5:0]  ctl;
        logic [4:0]  rd;
        logic [63:0] alu, rb, pct, pc;
        logic        zero;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic in_t mk_in(logic [6:0] ctl, logic [3:0] op, logic [4:0] rd,
                                  logic [63:0] a, logic [63:0] b, logic [63:0] imm,
                                  logic [63:0] pc, logic [1:0] fa, logic [1:0] fb,
                                  logic [63:0] wb, logic fl);
        in_t r;
        r.ctl = ctl; r.op = op; r.rd = rd; r.a = a; r.b = b; r.imm = imm;
        r.pc = pc; r.fa = fa; r.fb = fb; r.wb = wb; r.fl = fl;
        return r;
    endfunction

    function automatic exp_t mk_exp(logic stall, logic [5:0] ctl, logic [4:0] rd,
                                    logic [63:0] alu, logic [63:0] rb, logic [63:0] pct,
                                    logic [63:0] pc, logic zero);
        exp_t r;
        r.stall = stall; r.ctl = ctl; r.rd = rd; r.alu = alu; r.rb = rb;
        r.pct = pct; r.pc = pc; r.zero = zero;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue(input in_t i, input exp_t e);
        @(negedge clk);
        {RegWrite_EX, Branch_EX, Uncondbranch_EX, MemRead_EX,
         MemWrite_EX, Mem2Reg_EX, ALUSrc_EX} = i.ctl;
        ALUctrl_EX    = i.op;
        RD_EX         = i.rd;
        RegOutA_EX    = i.a;
        RegOutB_EX    = i.b;
        SignExtImm_EX = i.imm;
        pc_EX         = i.pc;
        ForwardA      = i.fa;
        ForwardB      = i.fb;
        WriteData_WB  = i.wb;
        flush_EX      = i.fl;
        q.push_back(e);
    endtask

    // Monitor: stall is checked mid-cycle, EX/MEM just after the capturing edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall_EX", 64'(stall_EX), 64'(e.stall));
                @(posedge clk);
                #1;
                chk("ctl_MEM", 64'({RegWrite_MEM, Branch_MEM, Uncondbranch_MEM,
                                    MemRead_MEM, MemWrite_MEM, Mem2Reg_MEM}), 64'(e.ctl));
                chk("RD_MEM", 64'(RD_MEM), 64'(e.rd));
                chk("ALUout_MEM", ALUout_MEM, e.alu);
                chk("RegOutB_MEM", RegOutB_MEM, e.rb);
                chk("PCtarget_MEM", PCtarget_MEM, e.pct);
                chk("pc_MEM", pc_MEM, e.pc);
                chk("ALUzero_MEM", 64'(ALUzero_MEM), 64'(e.zero));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        exp_t bub, bub_st;
        in_t  mi;
        bub    = mk_exp(1'b0, 6'd0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        bub_st = mk_exp(1'b1, 6'd0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);

        // Reset with every input pre-driven nonzero, including a MUL opcode.
        reset = 1'b1;
        mi = mk_in(7'h7F, 4'b1000, 5'd31, 64'h11, 64'h22, 64'h33, 64'h44,
                   2'b10, 2'b01, 64'h55, 1'b0);
        issue(mi, bub);
        issue(mi, bub);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // ADD 5 + 7 via immediate
        issue(mk_in(7'b1000001, 4'b0010, 5'd1, 64'd5, 64'd0, 64'd7, 64'd0, 2'b00, 2'b00, 64'd0, 1'b0),
              mk_exp(1'b0, 6'b100000, 5'd1, 64'd12, 64'd0, 64'd28, 64'd0, 1'b0));
        // SUB 9 - 9 with branch target 0x100 + (-4 << 2)
        issue(mk_in(7'b0100000, 4'b0110, 5'd2, 64'd9, 64'd9, -64'sd4, 64'h100, 2'b00, 2'b00, 64'd0, 1'b0),
              mk_exp(1'b0, 6'b010000, 5'd2, 64'd0, 64'd9, 64'hF0, 64'h100, 1'b1));
        // ADD producing 0x20, then forwarded from EX/MEM (A) and WB (B)
        issue(mk_in(7'b1000001, 4'b0010, 5'd3, 64'h1F, 64'd0, 64'd1, 64'd0, 2'b00, 2'b00, 64'd0, 1'b0),
              mk_exp(1'b0, 6'b100000, 5'd3, 64'h20, 64'd0, 64'd4, 64'd0, 1'b0));
        issue(mk_in(7'b1000101, 4'b0010, 5'd4, 64'h999, 64'h777, 64'd1, 64'd0, 2'b10, 2'b01, 64'hAB, 1'b0),
              mk_exp(1'b0, 6'b100010, 5'd4, 64'h21, 64'hAB, 64'd4, 64'd0, 1'b0));

        // MUL 0xFFFFFFFF * 3: 17 stall cycles, then the product
        mi = mk_in(7'b1000000, 4'b1000, 5'd5, 64'hFFFF_FFFF, 64'd3, 64'd2, 64'h40,
                   2'b00, 2'b00, 64'd0, 1'b0);
        for (int i = 0; i < 17; i++) issue(mi, bub_st);
        issue(mi, mk_exp(1'b0, 6'b100000, 5'd5, 64'h2_FFFF_FFFD, 64'd3, 64'h48, 64'h40, 1'b0));

        // Back-to-back MUL 2^63 * 2 wraps to 0
        mi = mk_in(7'b1000000, 4'b1000, 5'd6, 64'h8000_0000_0000_0000, 64'd2, 64'd0, 64'h80,
                   2'b00, 2'b00, 64'd0, 1'b0);
        for (int i = 0; i < 17; i++) issue(mi, bub_st);
        issue(mi, mk_exp(1'b0, 6'b100000, 5'd6, 64'd0, 64'd2, 64'h80, 64'h80, 1'b1));

        // MUL flushed in BUSY iteration 5, then an ADD completes in one cycle
        mi = mk_in(7'b1000000, 4'b1000, 5'd7, 64'd7, 64'd9, 64'd0, 64'h180,
                   2'b00, 2'b00, 64'd0, 1'b0);
        for (int i = 0; i < 6; i++) issue(mi, bub_st);
        mi.fl = 1'b1;
        issue(mi, bub);
        issue(mk_in(7'b1000001, 4'b0010, 5'd8, 64'd2, 64'd0, 64'd3, 64'h200, 2'b00, 2'b00, 64'd0, 1'b0),
              mk_exp(1'b0, 6'b100000, 5'd8, 64'd5, 64'd0, 64'h20C, 64'h200, 1'b0));

        // Shifts, undefined opcode, logic ops and pass-B
        issue(mk_in(7'b1000001, 4'b1001, 5'd9, 64'd1, 64'd0, 64'd63, 64'd0, 2'b00, 2'b00, 64'd0, 1'b0),
              mk_exp(1'b0, 6'b100000, 5'd9, 64'h8000_0000_0000_0000, 64'd0, 64'hFC, 64'd0, 1'b0));
        issue(mk_in(7'b1000001, 4'b1010, 5'd10, 64'h8000_0000_0000_0000, 64'd0, 64'd63, 64'd0, 2'b00, 2'b00, 64'd0, 1'b0),
              mk_exp(1'b0, 6'b100000, 5'd10, 64'd1, 64'd0, 64'hFC, 64'd0, 1'b0));
        issue(mk_in(7'b1000001, 4'b1111, 5'd11, 64'd5, 64'd0, 64'd3, 64'd0, 2'b00, 2'b00, 64'd0, 1'b0),
              mk_exp(1'b0, 6'b100000, 5'd11, 64'd0, 64'd0, 64'd12, 64'd0, 1'b1));
        issue(mk_in(7'b1000000, 4'b0000, 5'd12, 64'hF0F0, 64'hFF00, 64'd0, 64'd0, 2'b00, 2'b11, 64'hDEAD, 1'b0),
              mk_exp(1'b0, 6'b100000, 5'd12, 64'hF000, 64'hFF00, 64'd0, 64'd0, 1'b0));
        issue(mk_in(7'b1000000, 4'b0001, 5'd13, 64'hF0F0, 64'hFF00, 64'd0, 64'd0, 2'b00, 2'b00, 64'd0, 1'b0),
              mk_exp(1'b0, 6'b100000, 5'd13, 64'hFFF0, 64'hFF00, 64'd0, 64'd0, 1'b0));
        issue(mk_in(7'b0001010, 4'b0111, 5'd14, 64'h5, 64'h1234, 64'd0, 64'h10, 2'b00, 2'b00, 64'd0, 1'b0),
              mk_exp(1'b0, 6'b000101, 5'd14, 64'h1234, 64'h1234, 64'h10, 64'h10, 1'b0));

        repeat (4) @(negedge clk);
        chk("scoreboard_drain", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
